// File: rtl/alu_operand_fetch.sv
// ALU operand fetch stage: 8-entry register file, A/B latches, B shifter and operand muxes.
// Optional write-forwarding into the A/B latches during READ_A/READ_B is enabled by defining WB_BYPASS_EN.
module alu_operand_fetch #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [REG_AW-1:0] cmd_rn,
  input  logic [REG_AW-1:0] cmd_rm,
  input  logic [1:0]        cmd_shift,
  input  logic              cmd_asel,
  input  logic              cmd_bsel,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_num,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int unsigned DEPTH = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   rf_q [DEPTH];
  logic [DATA_W-1:0]   a_q, b_q, imm_q;
  logic [REG_AW-1:0]   rn_q, rm_q;
  logic [1:0]          shift_q;
  logic                asel_q, bsel_q;
  logic                fwd_a, fwd_b;
  logic [DATA_W-1:0]   a_d, b_d, b_shift;

`ifdef WB_BYPASS_EN
  assign fwd_a = wb_en && (wb_num == rn_q);
  assign fwd_b = wb_en && (wb_num == rm_q);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // The file array is read before this edge's write lands, giving read-before-write by default.
  assign a_d = fwd_a ? wb_data : rf_q[rn_q];
  assign b_d = fwd_b ? wb_data : rf_q[rm_q];

  assign cmd_ready = (state_q == IDLE);
  assign op_valid  = (state_q == DONE);

  always_comb begin
    b_shift = b_q;
    unique case (shift_q)
      2'b01:   b_shift = {b_q[DATA_W-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[DATA_W-1:1]};
      2'b11:   b_shift = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: b_shift = b_q;
    endcase
    Ain = '0;
    Bin = '0;
    if (state_q == DONE) begin
      Ain = asel_q ? '0 : a_q;
      Bin = bsel_q ? imm_q : b_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (wb_en) begin
        rf_q[wb_num] <= wb_data;
      end
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            rn_q    <= cmd_rn;
            rm_q    <= cmd_rm;
            shift_q <= cmd_shift;
            asel_q  <= cmd_asel;
            bsel_q  <= cmd_bsel;
            imm_q   <= cmd_imm;
            state_q <= READ_A;
          end
        end
        READ_A: begin
          a_q     <= a_d;
          state_q <= READ_B;
        end
        READ_B: begin
          b_q     <= b_d;
          state_q <= DONE;
        end
        DONE: begin
          if (op_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
